// File: rtl/phj_partition_pkg.sv
// Shared types for the partition combiner.
//   tuple_t / tag_t / line_t / sn_t : data widths on the hasher and writer sides
//   pc_state_t                      : combiner control state
//   SLOTS                           : tuples per 512-bit line
package phj_partition_pkg;

    typedef logic [63:0]  tuple_t;
    typedef logic [31:0]  tag_t;
    typedef logic [511:0] line_t;
    typedef logic [63:0]  sn_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } pc_state_t;

    localparam int SLOTS = 8;

endpackage

// File: rtl/partition_combiner_if.sv
// Bus between a hasher lane, the partition combiner and the partition writer.
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid && ready; the sender holds its payload stable while
// valid && !ready, and ready may depend combinationally on the other side.
//   master : hasher/writer side (drives in_*, out_ready)
//   slave  : combiner side (drives in_ready, out_*)
interface partition_combiner_if #(
    parameter int NUM_PARTITIONS = 16
);
    import phj_partition_pkg::*;

    localparam int PB = $clog2(NUM_PARTITIONS);

    logic            in_ready;
    tuple_t          in_tuple;
    tag_t            in_tag;
    logic            in_valid;
    logic            in_last_processed;
    sn_t             in_serialnum;

    logic            out_ready;
    logic            out_valid;
    line_t           out_data;
    logic [PB-1:0]   out_partition;
    logic [3:0]      out_count;
    sn_t             out_serialnum;
    logic            out_done;

    modport master (
        output in_tuple, in_tag, in_valid, in_last_processed, in_serialnum, out_ready,
        input  in_ready, out_valid, out_data, out_partition, out_count, out_serialnum, out_done
    );

    modport slave (
        input  in_tuple, in_tag, in_valid, in_last_processed, in_serialnum, out_ready,
        output in_ready, out_valid, out_data, out_partition, out_count, out_serialnum, out_done
    );

endinterface

// File: rtl/partition_line_store.sv
// Per-partition line buffers plus the serial number of the last tuple written
// into each partition.
//   clk                         : clock
//   wr_en/wr_part/wr_slot       : write one 64-bit slot of one line
//   wr_tuple/wr_sn              : slot data and serial number recorded with it
//   rd_part -> rd_line/rd_sn    : combinational read of one whole line
// Contents are not reset: validity of each slot is tracked by the fill
// counters in the top module.
module partition_line_store
    import phj_partition_pkg::*;
#(
    parameter  int NUM_PARTITIONS = 16,
    localparam int PB = $clog2(NUM_PARTITIONS),
    localparam int SW = $clog2(SLOTS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [PB-1:0] wr_part,
    input  logic [SW-1:0] wr_slot,
    input  tuple_t        wr_tuple,
    input  sn_t           wr_sn,
    input  logic [PB-1:0] rd_part,
    output line_t         rd_line,
    output sn_t           rd_sn
);

    line_t lines_q [NUM_PARTITIONS];
    sn_t   sn_q    [NUM_PARTITIONS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            lines_q[wr_part][int'(wr_slot) * $bits(tuple_t) +: $bits(tuple_t)] <= wr_tuple;
            sn_q[wr_part] <= wr_sn;
        end
    end

    assign rd_line = lines_q[rd_part];
    assign rd_sn   = sn_q[rd_part];

endmodule

// File: rtl/partition_combiner.sv
// Write-combining stage behind one hasher lane. Tuples are packed into
// per-partition 512-bit lines (partition = low tag bits); full lines go out
// immediately, and end-of-stream flushes every partial line before a single
// out_done pulse.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : slave side of partition_combiner_if (tuple in, line out)
//   dbg_state   : current control state
//   stat_tuples, stat_lines : saturating counters, only when
//                 PARTITION_COMBINER_STATS_EN is defined
module partition_combiner
    import phj_partition_pkg::*;
#(
    parameter int NUM_PARTITIONS  = 16,
    parameter int TUPLES_PER_LINE = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    partition_combiner_if.slave  bus,
    output pc_state_t            dbg_state
`ifdef PARTITION_COMBINER_STATS_EN
    ,
    output logic [47:0]          stat_tuples,
    output logic [47:0]          stat_lines
`endif
);

    localparam int PB = $clog2(NUM_PARTITIONS);
    localparam int CW = $clog2(TUPLES_PER_LINE);

    typedef logic [PB-1:0] part_t;

    pc_state_t     state_q, state_d;
    part_t         flush_q, flush_d;
    logic [CW-1:0] cnt_q [NUM_PARTITIONS];
    logic          live_q;
    logic          done;

    logic          out_valid_q;
    line_t         out_data_q;
    part_t         out_part_q;
    logic [3:0]    out_count_q;
    sn_t           out_sn_q;

    line_t         rd_line;
    sn_t           rd_sn;
    part_t         rd_part;
    part_t         in_part;
    logic [CW-1:0] in_slot;
    logic          out_free;
    logic          accept;
    logic          line_full;
    logic          flush_load;
    logic          unused_tag;

    assign in_part    = bus.in_tag[PB-1:0];
    assign unused_tag = ^bus.in_tag[$bits(tag_t)-1:PB];
    assign in_slot    = cnt_q[in_part];
    assign out_free   = !out_valid_q || bus.out_ready;

    // live_q keeps in_ready low while reset is applied and for the first edge after.
    assign bus.in_ready = live_q && (state_q == RUN) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign line_full    = accept && (in_slot == CW'(TUPLES_PER_LINE - 1));
    assign flush_load   = (state_q == FLUSH) && out_free && (cnt_q[flush_q] != '0);
    assign rd_part      = (state_q == FLUSH) ? flush_q : in_part;

    partition_line_store #(
        .NUM_PARTITIONS(NUM_PARTITIONS)
    ) u_store (
        .clk      (clk),
        .wr_en    (accept),
        .wr_part  (in_part),
        .wr_slot  (in_slot),
        .wr_tuple (bus.in_tuple),
        .wr_sn    (bus.in_serialnum),
        .rd_part  (rd_part),
        .rd_line  (rd_line),
        .rd_sn    (rd_sn)
    );

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        done    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (accept && bus.in_last_processed) begin
                    state_d = FLUSH;
                    flush_d = '0;
                end
            end
            FLUSH: begin
                // One partition per free output cycle, empty or not.
                if (out_free) begin
                    flush_d = flush_q + 1'b1;
                    if (flush_q == part_t'(NUM_PARTITIONS - 1)) state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    done    = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
            flush_q <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            live_q  <= 1'b1;
        end
    end

    // Accepts only happen in RUN and flush clears only in FLUSH, so the two never collide.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PARTITIONS; i++) cnt_q[i] <= '0;
        end else if (accept) begin
            cnt_q[in_part] <= in_slot + 1'b1;
        end else if (flush_load) begin
            cnt_q[flush_q] <= '0;
        end
    end

    // A completing tuple goes straight into slot 7 of the outgoing line; the
    // store still holds only slots 0..6 this cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_part_q  <= '0;
            out_count_q <= '0;
            out_sn_q    <= '0;
        end else if (line_full) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {bus.in_tuple, rd_line[$bits(line_t)-$bits(tuple_t)-1:0]};
            out_part_q  <= in_part;
            out_count_q <= 4'(TUPLES_PER_LINE);
            out_sn_q    <= bus.in_serialnum;
        end else if (flush_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rd_line;
            out_part_q  <= flush_q;
            out_count_q <= 4'(cnt_q[flush_q]);
            out_sn_q    <= rd_sn;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_partition = out_part_q;
    assign bus.out_count     = out_count_q;
    assign bus.out_serialnum = out_sn_q;
    assign bus.out_done      = done;
    assign dbg_state         = state_q;

`ifdef PARTITION_COMBINER_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_tuples <= '0;
            stat_lines  <= '0;
        end else begin
            if (accept && !(&stat_tuples)) stat_tuples <= stat_tuples + 48'd1;
            if (out_valid_q && bus.out_ready && !(&stat_lines)) stat_lines <= stat_lines + 48'd1;
        end
    end
`endif

endmodule

// File: tb/tb_partition_combiner.sv
// Directed bench for partition_combiner (NUM_PARTITIONS = 16).
// Tuple values carry serial number tuple + 0x1000, so an expected line is
// fully described by {partition, count, first tuple}.
module tb_partition_combiner;
    import phj_partition_pkg::*;

    localparam int NP = 16;
    localparam int W  = 76;  // {part[75:68], count[67:64], base[63:0]}

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    partition_combiner_if #(.NUM_PARTITIONS(NP)) bus ();
    pc_state_t dbg_state;
`ifdef PARTITION_COMBINER_STATS_EN
    logic [47:0] stat_tuples;
    logic [47:0] stat_lines;
`endif

    partition_combiner #(
        .NUM_PARTITIONS (NP),
        .TUPLES_PER_LINE(8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef PARTITION_COMBINER_STATS_EN
        ,
        .stat_tuples(stat_tuples),
        .stat_lines (stat_lines)
`endif
    );

    int n_vec    = 0;
    int n_err    = 0;
    int n_done   = 0;
    int exp_done = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    typedef struct {
        logic [63:0] tup;
        logic [31:0] tag;
        logic        last;
        logic        full;
        int          n_exp;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        int          done_lat;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [W-1:0] line(input int p, input int c, input logic [63:0] base);
        return {8'(p), 4'(c), base};
    endfunction

    function automatic vec_t mk(input logic [63:0] tup, input logic [31:0] tag, input logic last,
                                input logic full, input int n_exp, input logic [W-1:0] e0,
                                input logic [W-1:0] e1, input int done_lat);
        vec_t v;
        v.tup = tup; v.tag = tag; v.last = last; v.full = full;
        v.n_exp = n_exp; v.e0 = e0; v.e1 = e1; v.done_lat = done_lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Idle in_last_processed is left at 1 so a stray flush without in_valid shows up.
    task automatic send(input logic [63:0] tup, input logic [31:0] tag, input logic last);
        int guard = 0;
        bus.in_valid          = 1'b1;
        bus.in_tuple          = tup;
        bus.in_tag            = tag;
        bus.in_serialnum      = tup + 64'h1000;
        bus.in_last_processed = last;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, want 1", guard);
        end
        @(posedge clk);
        #1;
        bus.in_valid          = 1'b0;
        bus.in_last_processed = 1'b1;
    endtask

    task automatic wait_done(input int exp_lat);
        int   k    = 0;
        logic seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            seen = bus.out_done;
        end
        exp_done++;
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: out_done 0 for %0d cycles, want a pulse", k);
        end else begin
            if (exp_lat > 0) check("done_latency", 64'(k), 64'(exp_lat));
            @(negedge clk);
            check("done_one_cycle", 64'(bus.out_done), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_done", 64'(bus.out_done), 64'd0);
        check("rst_out_partition", 64'(bus.out_partition), 64'd0);
        check("rst_out_count", 64'(bus.out_count), 64'd0);
        check("rst_out_serialnum", bus.out_serialnum, 64'd0);
        check("rst_out_data_nonzero", 64'(|bus.out_data), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(RUN));
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (resetn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_line: got partition %0d count %0d, want no line",
                         bus.out_partition, bus.out_count);
            end else begin
                mon_e = exp_q.pop_front();
                check("line_partition", 64'(bus.out_partition), 64'(mon_e[75:68]));
                check("line_count", 64'(bus.out_count), 64'(mon_e[67:64]));
                check("line_serialnum", bus.out_serialnum,
                      mon_e[63:0] + 64'(mon_e[67:64]) - 64'd1 + 64'h1000);
                for (int k = 0; k < int'(mon_e[67:64]); k++)
                    check($sformatf("line_slot%0d", k), bus.out_data[64*k +: 64], mon_e[63:0] + 64'(k));
            end
        end
        if (resetn && bus.out_done) n_done++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        // Vector table: 8 to p3, 3 to p0 + last on p15, 8 to p0, 8 to p5 with last on the 8th.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(64'h10 + 64'(i), 32'hABCD_0003, 1'b0, i == 7, (i == 7) ? 1 : 0,
                              line(3, 8, 64'h10), '0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(64'h20 + 64'(i), 32'h1234_5670, 1'b0, 1'b0, 0, '0, '0, 0));
        vecs.push_back(mk(64'h30, 32'hFFFF_FFFF, 1'b1, 1'b0, 2,
                          line(0, 3, 64'h20), line(15, 1, 64'h30), 18));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(64'h40 + 64'(i), 32'h0000_0100, 1'b0, i == 7, (i == 7) ? 1 : 0,
                              line(0, 8, 64'h40), '0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(64'h50 + 64'(i), 32'h0000_0035, i == 7, i == 7, (i == 7) ? 1 : 0,
                              line(5, 8, 64'h50), '0, (i == 7) ? 17 : 0));

        bus.in_valid          = 1'b0;
        bus.in_tuple          = '0;
        bus.in_tag            = '0;
        bus.in_serialnum      = '0;
        bus.in_last_processed = 1'b1;
        bus.out_ready         = 1'b1;
        do_reset();

        foreach (vecs[i]) begin
            if (vecs[i].n_exp > 0) exp_q.push_back(vecs[i].e0);
            if (vecs[i].n_exp > 1) exp_q.push_back(vecs[i].e1);
            send(vecs[i].tup, vecs[i].tag, vecs[i].last);
            check($sformatf("out_valid_after_accept_%0d", i), 64'(bus.out_valid), 64'(vecs[i].full));
            if (vecs[i].last) begin
                check("state_flush", 64'(dbg_state), 64'(FLUSH));
                wait_done(vecs[i].done_lat);
            end
        end

        // Backpressure: out_ready low for 5 cycles after the line appears.
        for (int i = 0; i < 7; i++) send(64'h60 + 64'(i), 32'h3, 1'b0);
        exp_q.push_back(line(3, 8, 64'h60));
        bus.out_ready = 1'b0;
        send(64'h67, 32'h3, 1'b0);
        check("bp_out_valid_rise", 64'(bus.out_valid), 64'd1);
        bus.in_valid          = 1'b1;
        bus.in_tuple          = 64'h68;
        bus.in_tag            = 32'h3;
        bus.in_serialnum      = 64'h68 + 64'h1000;
        bus.in_last_processed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            check("bp_out_valid_hold", 64'(bus.out_valid), 64'd1);
            check("bp_slot7_hold", bus.out_data[511:448], 64'h67);
            check("bp_slot0_hold", bus.out_data[63:0], 64'h60);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_on_release", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid          = 1'b0;
        bus.in_last_processed = 1'b1;
        exp_q.push_back(line(3, 8, 64'h68));
        for (int i = 1; i < 8; i++) send(64'h68 + 64'(i), 32'h3, 1'b0);

        // Reset with 5 tuples buffered on p2 and a full p4 line pending.
        for (int i = 0; i < 5; i++) send(64'h70 + 64'(i), 32'h2, 1'b0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(64'h78 + 64'(i), 32'h4, 1'b0);
        check("pending_line_valid", 64'(bus.out_valid), 64'd1);
        do_reset();
        bus.out_ready = 1'b1;
        exp_q.push_back(line(2, 8, 64'h80));
        for (int i = 0; i < 8; i++) send(64'h80 + 64'(i), 32'h2, 1'b0);
        exp_q.push_back(line(9, 1, 64'hA8));
        send(64'hA8, 32'h9, 1'b1);
        wait_done(17);

`ifdef PARTITION_COMBINER_STATS_EN
        do_reset();
        check("stat_tuples_reset", 64'(stat_tuples), 64'd0);
        exp_q.push_back(line(1, 8, 64'h90));
        exp_q.push_back(line(1, 8, 64'h98));
        exp_q.push_back(line(1, 4, 64'hA0));
        for (int i = 0; i < 20; i++) send(64'h90 + 64'(i), 32'h0000_0021, i == 19);
        wait_done(17);
        check("stat_tuples", 64'(stat_tuples), 64'd20);
        check("stat_lines", 64'(stat_lines), 64'd3);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("lines_outstanding", 64'(exp_q.size()), 64'd0);
        check("done_pulses", 64'(n_done), 64'(exp_done));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
